// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, branch conditions, FSM states and control bundle type
package ctrl_pkg;

  localparam int CTRL_OPC_W    = 4;
  localparam int CTRL_COND_W   = 3;
  localparam int CTRL_ALU_OP_W = 3;

  localparam logic [3:0] ADD  = 4'h0;
  localparam logic [3:0] SUB  = 4'h1;
  localparam logic [3:0] AND  = 4'h2;
  localparam logic [3:0] NOR  = 4'h3;
  localparam logic [3:0] SLL  = 4'h4;
  localparam logic [3:0] SRA  = 4'h5;
  localparam logic [3:0] SRL  = 4'h6;
  localparam logic [3:0] PADD = 4'h7;
  localparam logic [3:0] LW   = 4'h8;
  localparam logic [3:0] SW   = 4'h9;
  localparam logic [3:0] LHB  = 4'hA;
  localparam logic [3:0] LLB  = 4'hB;
  localparam logic [3:0] B    = 4'hC;
  localparam logic [3:0] CALL = 4'hD;
  localparam logic [3:0] RET  = 4'hE;
  localparam logic [3:0] ERR  = 4'hF;

  localparam logic [2:0] EQ   = 3'd0;
  localparam logic [2:0] NEQ  = 3'd1;
  localparam logic [2:0] GT   = 3'd2;
  localparam logic [2:0] LT   = 3'd3;
  localparam logic [2:0] GTE  = 3'd4;
  localparam logic [2:0] LTE  = 3'd5;
  localparam logic [2:0] OVFL = 3'd6;
  localparam logic [2:0] TR   = 3'd7;

  typedef enum logic [1:0] {DECODE, CALL_B, RET_B, HALT} state_t;

  typedef enum logic [1:0] {K_SINGLE, K_CALL, K_RET, K_ERR} op_kind_t;

  typedef struct packed {
    logic                     data_reg;
    logic                     call;
    logic                     rtrn;
    logic [CTRL_COND_W:0]     branch;
    logic                     mem_to_reg;
    logic                     reg_to_mem;
    logic [CTRL_ALU_OP_W-1:0] alu_op;
    logic                     alu_src;
    logic                     sign_ext_sel;
    logic [1:0]               load_imm;
    logic                     sp_wr;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// rtl/ctrl_sequencer_if.sv - instruction handshake and control bundle bus
// Optional perf counter signals exist only when CTRL_PERF_CNT_EN is defined.
interface ctrl_sequencer_if #(
  parameter int OPC_W    = ctrl_pkg::CTRL_OPC_W,
  parameter int COND_W   = ctrl_pkg::CTRL_COND_W,
  parameter int ALU_OP_W = ctrl_pkg::CTRL_ALU_OP_W
);
  logic                in_valid;
  logic                in_ready;
  logic [OPC_W-1:0]    opcode;
  logic [COND_W-1:0]   branch_cond;
  logic                stall;
  logic                flush;
  logic                out_valid;
  logic                data_reg;
  logic                call;
  logic                rtrn;
  logic [COND_W:0]     branch;
  logic                mem_to_reg;
  logic                reg_to_mem;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_src;
  logic                sign_ext_sel;
  logic [1:0]          load_imm;
  logic                sp_wr;
  logic                halt;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0]         issued_cnt;
  logic [15:0]         stall_cnt;
`endif

  modport master (
    output in_valid, opcode, branch_cond, stall, flush,
    input  in_ready, out_valid, data_reg, call, rtrn, branch, mem_to_reg, reg_to_mem,
           alu_op, alu_src, sign_ext_sel, load_imm, sp_wr, halt
`ifdef CTRL_PERF_CNT_EN
    , input issued_cnt, stall_cnt
`endif
  );

  modport slave (
    input  in_valid, opcode, branch_cond, stall, flush,
    output in_ready, out_valid, data_reg, call, rtrn, branch, mem_to_reg, reg_to_mem,
           alu_op, alu_src, sign_ext_sel, load_imm, sp_wr, halt
`ifdef CTRL_PERF_CNT_EN
    , output issued_cnt, stall_cnt
`endif
  );

endinterface

// File: rtl/ctrl_decode_rom.sv
// rtl/ctrl_decode_rom.sv - combinational opcode table for single-beat ops and beat A
module ctrl_decode_rom
  import ctrl_pkg::*;
#(
  parameter int OPC_W = CTRL_OPC_W
) (
  input  logic [OPC_W-1:0]       opcode,
  input  logic [CTRL_COND_W-1:0] cond,
  output ctrl_bundle_t           bundle,
  output op_kind_t               kind
);

  logic [3:0] op4;
  logic       out_of_range;

  assign op4          = opcode[3:0];
  assign out_of_range = (opcode > OPC_W'(15));

  always_comb begin
    bundle = '0;
    kind   = K_SINGLE;
    if (out_of_range) begin
      kind = K_ERR;
    end else if (!op4[3]) begin
      // ALU group: the low opcode bits are the ALU operation; shifts/adds 4-7 sign-extend
      bundle.alu_op       = op4[2:0];
      bundle.sign_ext_sel = op4[2];
      bundle.branch       = {1'b0, cond};
    end else begin
      case (op4)
        LW: begin
          bundle.data_reg   = 1'b1;
          bundle.mem_to_reg = 1'b1;
          bundle.alu_src    = 1'b1;
        end
        SW: begin
          bundle.data_reg   = 1'b1;
          bundle.reg_to_mem = 1'b1;
          bundle.alu_src    = 1'b1;
        end
        LHB: begin
          bundle.load_imm = 2'b10;
          bundle.alu_src  = 1'b1;
        end
        LLB: begin
          bundle.load_imm = 2'b01;
          bundle.alu_src  = 1'b1;
        end
        B: begin
          bundle.branch = {1'b1, cond};
          bundle.alu_op = 3'b001;
        end
        CALL: begin
          kind              = K_CALL;
          bundle.call       = 1'b1;
          bundle.reg_to_mem = 1'b1;
          bundle.sp_wr      = 1'b1;
          bundle.alu_op     = 3'b001;
        end
        RET: begin
          kind              = K_RET;
          bundle.rtrn       = 1'b1;
          bundle.mem_to_reg = 1'b1;
          bundle.sp_wr      = 1'b1;
        end
        default: kind = K_ERR;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - registered control sequencer with CALL/RET micro-sequences
// Define CTRL_PERF_CNT_EN to add issued_cnt/stall_cnt performance counters.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPC_W       = CTRL_OPC_W,
  parameter int COND_W      = CTRL_COND_W,
  parameter int ALU_OP_W    = CTRL_ALU_OP_W,
  parameter bit HALT_ON_ERR = 1'b1
) (
  input logic            clk,
  input logic            rst,
  ctrl_sequencer_if.slave bus
);

  state_t       state_q, state_d;
  logic         halt_q, halt_d;
  logic         valid_q, valid_d;
  ctrl_bundle_t ctrl_q, ctrl_d;
  ctrl_bundle_t rom_bundle;
  op_kind_t     rom_kind;
  logic         accept;

  ctrl_decode_rom #(.OPC_W(OPC_W)) u_rom (
    .opcode (bus.opcode),
    .cond   (bus.branch_cond),
    .bundle (rom_bundle),
    .kind   (rom_kind)
  );

  assign bus.in_ready = (state_q == DECODE) && !bus.stall && !halt_q;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DECODE;
      halt_q  <= 1'b0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    if (bus.flush) begin
      // Flush outranks stall and discards anything accepted this cycle; halt stays sticky
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (state_q != HALT) state_d = DECODE;
    end else if (!bus.stall) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      unique case (state_q)
        DECODE: begin
          if (accept) begin
            unique case (rom_kind)
              K_SINGLE: begin
                valid_d = 1'b1;
                ctrl_d  = rom_bundle;
              end
              K_CALL: begin
                valid_d = 1'b1;
                ctrl_d  = rom_bundle;
                state_d = CALL_B;
              end
              K_RET: begin
                valid_d = 1'b1;
                ctrl_d  = rom_bundle;
                state_d = RET_B;
              end
              K_ERR: begin
                if (HALT_ON_ERR) begin
                  halt_d  = 1'b1;
                  state_d = HALT;
                end
              end
            endcase
          end
        end
        CALL_B, RET_B: begin
          valid_d       = 1'b1;
          ctrl_d.branch = {1'b1, {COND_W{1'b1}}};
          ctrl_d.rtrn   = (state_q == RET_B);
          state_d       = DECODE;
        end
        HALT: state_d = HALT;
        default: state_d = DECODE;
      endcase
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.data_reg     = ctrl_q.data_reg;
  assign bus.call         = ctrl_q.call;
  assign bus.rtrn         = ctrl_q.rtrn;
  assign bus.branch       = (COND_W + 1)'(ctrl_q.branch);
  assign bus.mem_to_reg   = ctrl_q.mem_to_reg;
  assign bus.reg_to_mem   = ctrl_q.reg_to_mem;
  assign bus.alu_op       = ALU_OP_W'(ctrl_q.alu_op);
  assign bus.alu_src      = ctrl_q.alu_src;
  assign bus.sign_ext_sel = ctrl_q.sign_ext_sel;
  assign bus.load_imm     = ctrl_q.load_imm;
  assign bus.sp_wr        = ctrl_q.sp_wr;
  assign bus.halt         = halt_q;

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] issued_q;
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= 16'd0;
      stall_q  <= 16'd0;
    end else begin
      if (valid_q && !bus.stall) issued_q <= issued_q + 16'd1;
      if (bus.stall)             stall_q  <= stall_q + 16'd1;
    end
  end

  assign bus.issued_cnt = issued_q;
  assign bus.stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - directed bench with queue-based beat model for ctrl_sequencer
// Checks the CTRL_PERF_CNT_EN counters too when that macro is defined.
module tb_ctrl_sequencer;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_sequencer_if bus ();

  ctrl_sequencer #(.HALT_ON_ERR(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic run_chk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bundle layout: dr call rtrn branch[3:0] m2r r2m alu_op[2:0] src sext load_imm[1:0] sp
  function automatic logic [16:0] mk(input logic dr, input logic cl, input logic rt,
                                     input logic [3:0] br, input logic m2r, input logic r2m,
                                     input logic [2:0] aop, input logic src, input logic sx,
                                     input logic [1:0] li, input logic sp);
    return {dr, cl, rt, br, m2r, r2m, aop, src, sx, li, sp};
  endfunction

  logic [16:0] m_q[$];
  logic [16:0] m_out  = '0;
  logic        m_valid = 1'b0;
  logic        m_halt  = 1'b0;
  logic [15:0] m_iss   = '0;
  logic [15:0] m_stl   = '0;

  // Each accepted instruction becomes a list of beats; the model just plays them out.
  task automatic expand(input logic [3:0] op, input logic [2:0] c);
    if (op <= 4'd7)
      m_q.push_back(mk(1'b0, 1'b0, 1'b0, {1'b0, c}, 1'b0, 1'b0, op[2:0], 1'b0, op >= 4'd4, 2'b00, 1'b0));
    else if (op == 4'd8)
      m_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0));
    else if (op == 4'd9)
      m_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0));
    else if (op == 4'd10)
      m_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'b10, 1'b0));
    else if (op == 4'd11)
      m_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'b01, 1'b0));
    else if (op == 4'd12)
      m_q.push_back(mk(1'b0, 1'b0, 1'b0, {1'b1, c}, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 2'b00, 1'b0));
    else if (op == 4'd13) begin
      m_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 2'b00, 1'b1));
      m_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0));
    end else if (op == 4'd14) begin
      m_q.push_back(mk(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b1));
      m_q.push_back(mk(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0));
    end else
      m_halt = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_out = '0; m_valid = 1'b0; m_halt = 1'b0; m_iss = '0; m_stl = '0;
    end else begin
      if (m_valid && !bus.stall) m_iss = m_iss + 16'd1;
      if (bus.stall) m_stl = m_stl + 16'd1;
      if (bus.flush) begin
        m_q.delete();
        m_out = '0; m_valid = 1'b0;
      end else if (!bus.stall) begin
        if (m_q.size() == 0 && !m_halt && bus.in_valid) expand(bus.opcode, bus.branch_cond);
        if (m_q.size() > 0) begin
          m_out = m_q.pop_front(); m_valid = 1'b1;
        end else begin
          m_out = '0; m_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("bundle", {14'b0, bus.out_valid, bus.data_reg, bus.call, bus.rtrn, bus.branch,
                     bus.mem_to_reg, bus.reg_to_mem, bus.alu_op, bus.alu_src,
                     bus.sign_ext_sel, bus.load_imm, bus.sp_wr},
                    {14'b0, m_valid, m_out});
      chk("in_ready", {31'b0, bus.in_ready},
          {31'b0, (m_q.size() == 0) && !bus.stall && !m_halt});
      chk("halt", {31'b0, bus.halt}, {31'b0, m_halt});
`ifdef CTRL_PERF_CNT_EN
      chk("issued_cnt", {16'b0, bus.issued_cnt}, {16'b0, m_iss});
      chk("stall_cnt", {16'b0, bus.stall_cnt}, {16'b0, m_stl});
`endif
    end
  end

  task automatic step(input logic v, input logic [3:0] op, input logic [2:0] c,
                      input logic st, input logic fl);
    bus.in_valid = v; bus.opcode = op; bus.branch_cond = c; bus.stall = st; bus.flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.opcode = '0; bus.branch_cond = '0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    run_chk = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_halt", {31'b0, bus.halt}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    step(1'b1, ADD, 3'd3, 1'b0, 1'b0);
    chk("add_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("add_branch", {28'b0, bus.branch}, 32'h3);
    chk("add_alu_op", {29'b0, bus.alu_op}, 32'h0);
    chk("add_alu_src", {31'b0, bus.alu_src}, 32'd0);

    step(1'b1, LW, 3'd0, 1'b0, 1'b0);
    chk("lw_ctrl", {29'b0, bus.data_reg, bus.mem_to_reg, bus.alu_src}, 32'h7);
    chk("lw_in_ready", {31'b0, bus.in_ready}, 32'd1);
    step(1'b1, SW, 3'd0, 1'b0, 1'b0);
    chk("sw_ctrl", {29'b0, bus.data_reg, bus.reg_to_mem, bus.mem_to_reg}, 32'h6);

    step(1'b1, CALL, 3'd2, 1'b0, 1'b0);
    chk("call_a", {26'b0, bus.call, bus.reg_to_mem, bus.sp_wr, bus.alu_op}, 32'h39);
    chk("call_a_ready", {31'b0, bus.in_ready}, 32'd0);
    step(1'b0, ADD, 3'd0, 1'b0, 1'b0);
    chk("call_b_branch", {27'b0, bus.out_valid, bus.branch}, 32'h1F);
    chk("call_b_ready", {31'b0, bus.in_ready}, 32'd1);

    step(1'b1, RET, 3'd0, 1'b0, 1'b0);
    chk("ret_a_rtrn", {31'b0, bus.rtrn}, 32'd1);
    step(1'b0, ADD, 3'd0, 1'b0, 1'b1);
    chk("ret_flush_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("ret_flush_ready", {31'b0, bus.in_ready}, 32'd1);
    step(1'b0, ADD, 3'd0, 1'b0, 1'b0);
    chk("ret_no_beat_b", {31'b0, bus.out_valid}, 32'd0);

    step(1'b1, SRA, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ADD, 3'd1, 1'b1, 1'b0);
      chk("sra_frozen", {27'b0, bus.out_valid, bus.sign_ext_sel, bus.alu_op}, 32'h1D);
    end
    step(1'b0, ADD, 3'd0, 1'b0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      step(1'b1, 4'(i), 3'(i * 3), 1'b0, 1'b0);
      if (i % 4 == 3) step(1'b0, ADD, 3'd0, 1'b0, 1'b0);
    end
    step(1'b1, B, TR, 1'b0, 1'b0);
    chk("b_branch", {28'b0, bus.branch}, 32'hF);

    step(1'b1, CALL, 3'd5, 1'b0, 1'b0);
    step(1'b1, LLB, 3'd0, 1'b1, 1'b0);
    step(1'b1, LLB, 3'd0, 1'b1, 1'b0);
    step(1'b1, LLB, 3'd0, 1'b0, 1'b0);
    step(1'b1, LHB, 3'd0, 1'b0, 1'b0);
    step(1'b1, RET, 3'd0, 1'b0, 1'b0);
    step(1'b1, RET, 3'd0, 1'b1, 1'b1);
    chk("flush_over_stall", {31'b0, bus.out_valid}, 32'd0);
    step(1'b1, CALL, 3'd0, 1'b0, 1'b1);
    step(1'b0, ADD, 3'd0, 1'b0, 1'b0);
    chk("call_in_flush_dropped", {31'b0, bus.out_valid}, 32'd0);

    step(1'b1, ERR, 3'd0, 1'b0, 1'b0);
    chk("err_halt", {30'b0, bus.halt, bus.out_valid}, 32'h2);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ADD, 3'd0, 1'b0, i == 2);
      chk("halt_ready", {30'b0, bus.halt, bus.in_ready}, 32'h2);
    end
    rst = 1'b1;
    step(1'b0, ADD, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_clears_halt", {30'b0, bus.halt, bus.in_ready}, 32'h1);
    step(1'b1, SUB, 3'd4, 1'b0, 1'b0);
    step(1'b0, ADD, 3'd0, 1'b0, 1'b0);
    step(1'b0, ADD, 3'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
